// File: rtl/fifo_bank_ctrl_pkg.sv
// Shared types and size helpers for the fifo bank sequencer.
// FIFO_BANK_CTRL_SKEW_EN selects the skewed drain length.
package fifo_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of DRAIN cycles.
    function automatic int drain_len(input int nf, input int d);
`ifdef FIFO_BANK_CTRL_SKEW_EN
        return d + nf - 1;
`else
        return d + 0 * nf;
`endif
    endfunction

endpackage

// File: rtl/fifo_bank_skew.sv
// Maps the drain cycle count onto per-fifo shift enables.
// FIFO_BANK_CTRL_SKEW_EN: lane i runs on cycles i..i+DEPTH-1; otherwise all lanes run together.
module fifo_bank_skew
    import fifo_bank_ctrl_pkg::*;
#(
    parameter int NUM_FIFO = 8,
    parameter int DEPTH    = 8,
    parameter int DW       = cnt_w(DEPTH + NUM_FIFO)
) (
    input  logic [DW-1:0]       drain_cnt_i,
    output logic [NUM_FIFO-1:0] en_o
);

    for (genvar i = 0; i < NUM_FIFO; i++) begin : g_lane
`ifdef FIFO_BANK_CTRL_SKEW_EN
        assign en_o[i] = (32'(drain_cnt_i) >= 32'(i)) &&
                         (32'(drain_cnt_i) <  32'(i + DEPTH));
`else
        assign en_o[i] = 32'(drain_cnt_i) < 32'(DEPTH);
`endif
    end

endmodule

// File: rtl/fifo_bank_ctrl.sv
// Fill/drain sequencer for a bank of NUM_FIFO delay fifos.
// FIFO_BANK_CTRL_SKEW_EN selects a lane-skewed drain (see fifo_bank_skew).
module fifo_bank_ctrl
    import fifo_bank_ctrl_pkg::*;
#(
    parameter int NUM_FIFO = 8,
    parameter int DEPTH    = 8,
    parameter int BITS     = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_data,
    output logic [NUM_FIFO-1:0] fifo_en,
    output logic [BITS-1:0]     fifo_d,
    output logic [NUM_FIFO-1:0] lane_valid,
    output logic                busy,
    output logic                done
);

    localparam int LW = cnt_w(NUM_FIFO);
    localparam int BW = cnt_w(DEPTH);
    localparam int DW = cnt_w(DEPTH + NUM_FIFO);
    localparam int T  = drain_len(NUM_FIFO, DEPTH);

    state_t        state_q, state_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          beat;
    logic [NUM_FIFO-1:0] skew_en;

    fifo_bank_skew #(
        .NUM_FIFO (NUM_FIFO),
        .DEPTH    (DEPTH),
        .DW       (DW)
    ) u_skew (
        .drain_cnt_i (drain_q),
        .en_o        (skew_en)
    );

    // abort wins over a beat presented in the same cycle
    assign beat = (state_q == FILL) && in_valid && !abort;

    always_comb begin
        in_ready = (state_q == FILL) && !abort;
        fifo_d   = (state_q == FILL) ? in_data : '0;
        fifo_en  = '0;
        if (beat) begin
            fifo_en[lane_q] = 1'b1;
        end else if (state_q == DRAIN && !abort) begin
            fifo_en = skew_en;
        end
    end

    assign lane_valid = fifo_en;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        if (abort) begin
            state_d = IDLE;
            lane_d  = '0;
            beat_d  = '0;
            drain_d = '0;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = FILL;
                FILL: begin
                    if (beat) begin
                        if (32'(beat_q) == 32'(DEPTH - 1)) begin
                            beat_d = '0;
                            if (32'(lane_q) == 32'(NUM_FIFO - 1)) begin
                                lane_d  = '0;
                                state_d = DRAIN;
                            end else begin
                                lane_d = lane_q + LW'(1);
                            end
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (32'(drain_q) == 32'(T - 1)) begin
                        drain_d = '0;
                        state_d = DONE;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            beat_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
        end
    end

endmodule
